// File: rtl/cmd_rx_mon_pkg.sv
// cmd_rx_mon_pkg: register map, CONF bit indices and capture FSM encoding shared with the command sequencer
package cmd_rx_mon_pkg;
    localparam logic [15:0] REG_RST    = 16'd0;
    localparam logic [15:0] REG_START  = 16'd1;
    localparam logic [15:0] REG_CONF   = 16'd2;
    localparam logic [15:0] REG_CNT    = 16'd3;
    localparam logic [15:0] REG_CNT_HI = 16'd4;
    localparam logic [15:0] REG_GAP    = 16'd5;
    localparam logic [15:0] REG_SPARE0 = 16'd6;
    localparam logic [15:0] REG_SPARE1 = 16'd7;
    localparam logic [15:0] MEM_BASE   = 16'd8;

    localparam int          CONF_EN_NEGEDGE = 0;
    localparam logic [7:0]  GAP_RESET       = 8'd16;

    // busy is bit 0 alone, so it leaves the CMD domain as a single flop
    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_WAIT_START = 2'b01,
        ST_CAPTURE    = 2'b11,
        ST_DONE       = 2'b10
    } rx_state_e;

    function automatic logic [7:0] eff_gap(input logic [7:0] g);
        return (g == 8'd0) ? 8'd1 : g;
    endfunction
endpackage

// File: rtl/cmd_rx_core.sv
// cmd_rx_core: CMD_CLK_IN-domain sampler, capture FSM and MSB-first bit packer driving the memory write port
module cmd_rx_core
    import cmd_rx_mon_pkg::*;
#(
    parameter  int MEM_SIZE = 2048,
    localparam int AW       = $clog2(MEM_SIZE),
    localparam int BW       = AW + 4
) (
    input  logic          clk_i,
    input  logic          rst_flag_i,
    input  logic          arm_i,
    input  logic          data_i,
    input  logic          neg_sample_i,
    input  logic [7:0]    gap_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          overflow_o,
    output logic [15:0]   bit_count_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_data_o
);
    localparam logic [BW-1:0] CAP = BW'(MEM_SIZE * 8);

    rx_state_e     state_q;
    logic          data_neg_q, sample_q, ovf_q, cap_end, gap_end;
    logic [BW-1:0] bit_ptr_q, last_one_q, cnt_q, ptr_nx;
    logic [7:0]    gap_cnt_q, sr_q, sr_nx, gap_nx;

    always_ff @(negedge clk_i)
        data_neg_q <= data_i;

    always_ff @(posedge clk_i)
        sample_q <= neg_sample_i ? data_neg_q : data_i;

    assign ptr_nx  = bit_ptr_q + 1'b1;
    assign sr_nx   = {sr_q[6:0], sample_q};
    assign gap_nx  = gap_cnt_q + 8'd1;
    assign cap_end = ptr_nx == CAP;
    assign gap_end = !sample_q && gap_nx == eff_gap(gap_i);

    always_ff @(posedge clk_i) begin
        if (rst_flag_i) begin
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (arm_i) begin
            state_q    <= ST_WAIT_START;
            bit_ptr_q  <= '0;
            last_one_q <= '0;
            gap_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else if (state_q == ST_WAIT_START && sample_q) begin
            state_q    <= ST_CAPTURE;
            bit_ptr_q  <= BW'(1);
            last_one_q <= BW'(1);
            gap_cnt_q  <= '0;
            sr_q       <= sr_nx;
        end else if (state_q == ST_CAPTURE) begin
            bit_ptr_q  <= ptr_nx;
            sr_q       <= sr_nx;
            last_one_q <= sample_q ? ptr_nx : last_one_q;
            gap_cnt_q  <= sample_q ? 8'd0 : gap_nx;
            if (cap_end) begin
                state_q <= ST_DONE;
                ovf_q   <= 1'b1;
                cnt_q   <= CAP;
            end else if (gap_end) begin
                state_q <= ST_DONE;
                cnt_q   <= last_one_q;
            end
        end
    end

    // a full byte has shift 0; the final partial byte lands left-aligned with zero fill
    assign mem_we_o    = state_q == ST_CAPTURE && (&bit_ptr_q[2:0] || gap_end);
    assign mem_addr_o  = bit_ptr_q[BW-2:3];
    assign mem_data_o  = sr_nx << (3'd7 - bit_ptr_q[2:0]);
    assign busy_o      = state_q[0];
    assign done_o      = state_q == ST_DONE;
    assign overflow_o  = ovf_q;
    assign bit_count_o = 16'(cnt_q);
endmodule

// File: rtl/flag_domain_crossing.sv
// flag_domain_crossing: carries a single-cycle flag from clk_a to clk_b as a toggle through three flops
module flag_domain_crossing (
    input  logic clk_a_i,
    input  logic clk_b_i,
    input  logic flag_i,
    output logic flag_o
);
    logic       tog_q;
    logic [2:0] sync_q;

    always_ff @(posedge clk_a_i)
        if (flag_i)
            tog_q <= ~tog_q;

    always_ff @(posedge clk_b_i)
        sync_q <= {sync_q[1:0], tog_q};

    assign flag_o = sync_q[2] ^ sync_q[1];
endmodule

// File: rtl/three_stage_synchronizer.sv
// three_stage_synchronizer: level synchronizer into the clk_i domain
module three_stage_synchronizer (
    input  logic clk_i,
    input  logic in_i,
    output logic out_o
);
    logic [2:0] sync_q;

    always_ff @(posedge clk_i)
        sync_q <= {sync_q[1:0], in_i};

    assign out_o = sync_q[2];
endmodule

// File: rtl/cmd_rx_mon.sv
// cmd_rx_mon: bus slave capturing the serial command link into a byte memory for loopback and debug
// Bus registers, clock-domain crossings and the memory read port live here; capture is in cmd_rx_core.
module cmd_rx_mon
    import cmd_rx_mon_pkg::*;
#(
    parameter int MEM_SIZE = 2048
) (
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic [15:0] BUS_ADD,
    input  logic [7:0]  BUS_DATA_IN,
    input  logic        BUS_RD,
    input  logic        BUS_WR,
    output logic [7:0]  BUS_DATA_OUT,
    input  logic        CMD_CLK_IN,
    input  logic        CMD_DATA_IN,
    output logic        CMD_RX_BUSY
);
    localparam int AW = $clog2(MEM_SIZE);

    logic [7:0]    conf_q, gap_q, spare0_q, spare1_q, reg_rd, mem_data;
    logic          soft_rst, rst_all, rst_all_q, arm_wr, arm_wr_q;
    logic          rst_cmd, arm_cmd, done_cmd, ovf, done_s, armed_s, mem_we, in_mem;
    logic [15:0]   bit_count, mem_off;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem [MEM_SIZE];

    assign soft_rst = BUS_WR && BUS_ADD == REG_RST;
    assign rst_all  = RST || soft_rst;
    assign arm_wr   = BUS_WR && BUS_ADD == REG_START;

    // rising edges only, so a held reset or write strobe crosses as a single flag
    always_ff @(posedge BUS_CLK) begin
        rst_all_q <= rst_all;
        arm_wr_q  <= arm_wr;
    end

    always_ff @(posedge BUS_CLK) begin
        if (rst_all) begin
            conf_q   <= 8'd0;
            gap_q    <= GAP_RESET;
            spare0_q <= 8'd0;
            spare1_q <= 8'd0;
        end else if (BUS_WR) begin
            conf_q   <= BUS_ADD == REG_CONF ? BUS_DATA_IN : conf_q;
            gap_q    <= BUS_ADD == REG_GAP ? BUS_DATA_IN : gap_q;
            spare0_q <= BUS_ADD == REG_SPARE0 ? BUS_DATA_IN : spare0_q;
            spare1_q <= BUS_ADD == REG_SPARE1 ? BUS_DATA_IN : spare1_q;
        end
    end

    flag_domain_crossing u_rst_cdc (
        .clk_a_i(BUS_CLK),
        .clk_b_i(CMD_CLK_IN),
        .flag_i (rst_all && !rst_all_q),
        .flag_o (rst_cmd)
    );

    flag_domain_crossing u_arm_cdc (
        .clk_a_i(BUS_CLK),
        .clk_b_i(CMD_CLK_IN),
        .flag_i (arm_wr && !arm_wr_q),
        .flag_o (arm_cmd)
    );

    cmd_rx_core #(.MEM_SIZE(MEM_SIZE)) u_core (
        .clk_i       (CMD_CLK_IN),
        .rst_flag_i  (rst_cmd),
        .arm_i       (arm_cmd),
        .data_i      (CMD_DATA_IN),
        .neg_sample_i(conf_q[CONF_EN_NEGEDGE]),
        .gap_i       (gap_q),
        .busy_o      (CMD_RX_BUSY),
        .done_o      (done_cmd),
        .overflow_o  (ovf),
        .bit_count_o (bit_count),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data)
    );

    three_stage_synchronizer u_done_sync (.clk_i(BUS_CLK), .in_i(done_cmd), .out_o(done_s));
    three_stage_synchronizer u_armed_sync (.clk_i(BUS_CLK), .in_i(CMD_RX_BUSY), .out_o(armed_s));

    always_ff @(posedge CMD_CLK_IN)
        if (mem_we)
            mem[mem_addr] <= mem_data;

    // bit count and overflow are stable once DONE is seen, so they are read without synchronizing
    assign mem_off = BUS_ADD - MEM_BASE;
    assign in_mem  = BUS_ADD >= MEM_BASE && mem_off < 16'(MEM_SIZE);
    assign reg_rd  = BUS_ADD == REG_START  ? {5'b0, armed_s, ovf, done_s} :
                     BUS_ADD == REG_CONF   ? conf_q :
                     BUS_ADD == REG_CNT    ? bit_count[7:0] :
                     BUS_ADD == REG_CNT_HI ? bit_count[15:8] :
                     BUS_ADD == REG_GAP    ? gap_q :
                     BUS_ADD == REG_SPARE0 ? spare0_q :
                     BUS_ADD == REG_SPARE1 ? spare1_q : 8'd0;

    always_ff @(negedge BUS_CLK)
        if (BUS_RD)
            BUS_DATA_OUT <= in_mem ? mem[mem_off[AW-1:0]] : reg_rd;
endmodule

// File: tb/tb_cmd_rx_mon.sv
// tb_cmd_rx_mon: directed register table and capture sequences for cmd_rx_mon (default and MEM_SIZE=4)
module tb_cmd_rx_mon;
    import cmd_rx_mon_pkg::*;

    logic        BUS_CLK = 0, RST = 1, BUS_RD = 0, BUS_WR = 0, CMD_CLK_IN = 0, CMD_DATA_IN = 0;
    logic [15:0] BUS_ADD = 0;
    logic [7:0]  BUS_DATA_IN = 0, BUS_DATA_OUT, BUS_DATA_OUT4;
    logic        CMD_RX_BUSY, CMD_RX_BUSY4;
    int          total = 0, bad = 0;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  data;
    } vec_t;
    vec_t tbl[$];

    always #5 BUS_CLK = ~BUS_CLK;
    always #7 CMD_CLK_IN = ~CMD_CLK_IN;

    cmd_rx_mon dut (
        .BUS_CLK(BUS_CLK), .RST(RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
        .BUS_RD(BUS_RD), .BUS_WR(BUS_WR), .BUS_DATA_OUT(BUS_DATA_OUT),
        .CMD_CLK_IN(CMD_CLK_IN), .CMD_DATA_IN(CMD_DATA_IN), .CMD_RX_BUSY(CMD_RX_BUSY)
    );

    cmd_rx_mon #(.MEM_SIZE(4)) dut4 (
        .BUS_CLK(BUS_CLK), .RST(RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
        .BUS_RD(BUS_RD), .BUS_WR(BUS_WR), .BUS_DATA_OUT(BUS_DATA_OUT4),
        .CMD_CLK_IN(CMD_CLK_IN), .CMD_DATA_IN(CMD_DATA_IN), .CMD_RX_BUSY(CMD_RX_BUSY4)
    );

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        @(posedge BUS_CLK); #1;
        BUS_ADD = a; BUS_DATA_IN = d; BUS_WR = 1;
        @(posedge BUS_CLK); #1;
        BUS_WR = 0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [7:0] d, output logic [7:0] d4);
        @(posedge BUS_CLK); #1;
        BUS_ADD = a; BUS_RD = 1;
        @(negedge BUS_CLK); #1;
        d = BUS_DATA_OUT; d4 = BUS_DATA_OUT4; BUS_RD = 0;
    endtask

    task automatic rchk(input string name, input logic [15:0] a, input logic [7:0] exp, input logic use4);
        logic [7:0] d, d4;
        bus_rd(a, d, d4);
        check(name, use4 ? d4 : d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CMD_CLK_IN);
        #1;
    endtask

    task automatic send(input logic [63:0] bits, input int n, input logic on_pos);
        for (int i = n - 1; i >= 0; i--) begin
            if (on_pos) @(posedge CMD_CLK_IN); else @(negedge CMD_CLK_IN);
            CMD_DATA_IN = bits[i];
        end
        if (on_pos) @(posedge CMD_CLK_IN); else @(negedge CMD_CLK_IN);
        CMD_DATA_IN = 0;
    endtask

    task automatic arm();
        bus_wr(REG_START, 8'h00);
        idle(6);
    endtask

    task automatic wait_done(input string name, input logic use4);
        logic [7:0] d, d4;
        logic seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            bus_rd(REG_START, d, d4);
            seen = use4 ? d4[0] : d[0];
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: DONE got 0 expected 1 within 200 reads", name);
        end
    endtask

    task automatic add(input logic [15:0] a, input logic w, input logic [7:0] d);
        tbl.push_back('{addr: a, wr: w, data: d});
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        add(REG_START, 0, 8'h00); add(REG_CONF, 0, 8'h00); add(REG_CNT, 0, 8'h00);
        add(REG_CNT_HI, 0, 8'h00); add(REG_GAP, 0, 8'd16); add(REG_SPARE0, 0, 8'h00);
        add(REG_SPARE1, 0, 8'h00); add(REG_RST, 0, 8'h00); add(16'hFFFF, 0, 8'h00);
        add(16'd2056, 0, 8'h00);
        add(REG_CONF, 1, 8'h5A); add(REG_GAP, 1, 8'h21); add(REG_SPARE0, 1, 8'hC3); add(REG_SPARE1, 1, 8'h3C);
        add(REG_CONF, 0, 8'h5A); add(REG_GAP, 0, 8'h21); add(REG_SPARE0, 0, 8'hC3); add(REG_SPARE1, 0, 8'h3C);
        add(REG_RST, 1, 8'h00);
        add(REG_CONF, 0, 8'h00); add(REG_GAP, 0, 8'd16); add(REG_SPARE0, 0, 8'h00); add(REG_SPARE1, 0, 8'h00);

        repeat (5) @(posedge BUS_CLK);
        #1 RST = 0;
        idle(6);
        check("busy_after_reset", {7'd0, CMD_RX_BUSY}, 8'h00);

        foreach (tbl[i]) begin
            if (tbl[i].wr) bus_wr(tbl[i].addr, tbl[i].data);
            else rchk($sformatf("vec%0d_addr%0h", i, tbl[i].addr), tbl[i].addr, tbl[i].data, 0);
        end

        // 1: three bytes A5 00 FF, the zero byte must not end the capture
        arm();
        send(64'hA500FF, 24, 0);
        idle(30);
        wait_done("t1_done", 0);
        rchk("t1_status", REG_START, 8'h01, 0);
        rchk("t1_cnt_lo", REG_CNT, 8'd24, 0);
        rchk("t1_cnt_hi", REG_CNT_HI, 8'h00, 0);
        rchk("t1_mem0", 16'd8, 8'hA5, 0);
        rchk("t1_mem1", 16'd9, 8'h00, 0);
        rchk("t1_mem2", 16'd10, 8'hFF, 0);

        // 2: leading zeros skipped, trailing idle excluded
        arm();
        send(64'b00101, 5, 0);
        idle(30);
        wait_done("t2_done", 0);
        rchk("t2_status", REG_START, 8'h01, 0);
        rchk("t2_cnt_lo", REG_CNT, 8'd3, 0);
        rchk("t2_mem0", 16'd8, 8'hA0, 0);

        // 3: 40 ones overflow the 4-byte instance, fit in the large one
        arm();
        send(64'hFF_FFFF_FFFF, 40, 0);
        wait_done("t3_done4", 1);
        rchk("t3_status4", REG_START, 8'h03, 1);
        rchk("t3_cnt_lo4", REG_CNT, 8'd32, 1);
        rchk("t3_cnt_hi4", REG_CNT_HI, 8'h00, 1);
        for (int i = 0; i < 4; i++) rchk($sformatf("t3_mem%0d_4", i), 16'(8 + i), 8'hFF, 1);
        rchk("t3_oob4", 16'd12, 8'h00, 1);
        idle(30);
        wait_done("t3_done", 0);
        rchk("t3_status", REG_START, 8'h01, 0);
        rchk("t3_cnt_lo", REG_CNT, 8'd40, 0);

        // 4: soft reset in the middle of a capture
        bus_wr(REG_CONF, 8'h02);
        bus_wr(REG_GAP, 8'd40);
        arm();
        send(64'b1011, 4, 0);
        rchk("t4_armed", REG_START, 8'h04, 0);
        check("t4_busy", {7'd0, CMD_RX_BUSY}, 8'h01);
        bus_wr(REG_RST, 8'h00);
        idle(8);
        check("t4_busy_rst", {7'd0, CMD_RX_BUSY}, 8'h00);
        rchk("t4_status", REG_START, 8'h00, 0);
        rchk("t4_cnt_lo", REG_CNT, 8'h00, 0);
        rchk("t4_cnt_hi", REG_CNT_HI, 8'h00, 0);
        rchk("t4_conf", REG_CONF, 8'h00, 0);
        rchk("t4_gap", REG_GAP, 8'd16, 0);
        arm();
        send(64'h81, 8, 0);
        idle(30);
        wait_done("t4_done", 0);
        rchk("t4_cnt_new", REG_CNT, 8'd8, 0);
        rchk("t4_mem0", 16'd8, 8'h81, 0);

        // 5: re-arm discards a partial capture
        arm();
        send(64'b11011, 5, 0);
        arm();
        send(64'hC3, 8, 0);
        idle(30);
        wait_done("t5_done", 0);
        rchk("t5_cnt_lo", REG_CNT, 8'd8, 0);
        rchk("t5_cnt_hi", REG_CNT_HI, 8'h00, 0);
        rchk("t5_mem0", 16'd8, 8'hC3, 0);

        // 6: negedge sampling with data moving on posedge, then IDLE_GAP=0 acting as 1
        bus_wr(REG_CONF, 8'h01);
        arm();
        send(64'h96, 8, 1);
        idle(30);
        wait_done("t6_done", 0);
        rchk("t6_cnt_lo", REG_CNT, 8'd7, 0);
        rchk("t6_mem0", 16'd8, 8'h96, 0);
        bus_wr(REG_GAP, 8'h00);
        arm();
        send(64'b101, 3, 1);
        idle(10);
        wait_done("t6_gap0_done", 0);
        rchk("t6_gap0_cnt", REG_CNT, 8'd1, 0);
        rchk("t6_gap0_mem0", 16'd8, 8'h80, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
